// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, access-size codes,
// requester ids and the burst-length decode.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ACC_1  = 2'b00;
  localparam logic [1:0] ACC_4  = 2'b01;
  localparam logic [1:0] ACC_8  = 2'b10;
  localparam logic [1:0] ACC_16 = 2'b11;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  function automatic logic [4:0] burst_len(input logic [1:0] acc);
    case (acc)
      ACC_1:   return 5'd1;
      ACC_4:   return 5'd4;
      ACC_8:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the arbiter and main memory.
// The arbiter takes the slave view; requesters and memory model take the master view.
interface mem_arbiter_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
);
  logic                    if_req;
  logic [ADDRESS_SIZE-1:0] if_addr;
  logic [ACCESS_SIZE-1:0]  if_acc_size;
  logic                    if_gnt;
  logic [DATA_SIZE-1:0]    if_rdata;
  logic                    if_rvalid;
  logic                    if_done;

  logic                    dm_req;
  logic [ADDRESS_SIZE-1:0] dm_addr;
  logic [ACCESS_SIZE-1:0]  dm_acc_size;
  logic                    dm_wren;
  logic [DATA_SIZE-1:0]    dm_wdata;
  logic                    dm_wack;
  logic                    dm_gnt;
  logic [DATA_SIZE-1:0]    dm_rdata;
  logic                    dm_rvalid;
  logic                    dm_done;

  logic                    mem_en;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [ACCESS_SIZE-1:0]  mem_acc_size;
  logic                    mem_wren;
  logic [DATA_SIZE-1:0]    mem_d_in;
  logic [DATA_SIZE-1:0]    mem_d_out;
  logic                    mem_busy;

  modport slave (
    input  if_req, if_addr, if_acc_size,
    output if_gnt, if_rdata, if_rvalid, if_done,
    input  dm_req, dm_addr, dm_acc_size, dm_wren, dm_wdata,
    output dm_wack, dm_gnt, dm_rdata, dm_rvalid, dm_done,
    output mem_en, mem_addr, mem_acc_size, mem_wren, mem_d_in,
    input  mem_d_out, mem_busy
  );

  modport master (
    output if_req, if_addr, if_acc_size,
    input  if_gnt, if_rdata, if_rvalid, if_done,
    output dm_req, dm_addr, dm_acc_size, dm_wren, dm_wdata,
    input  dm_wack, dm_gnt, dm_rdata, dm_rvalid, dm_done,
    input  mem_en, mem_addr, mem_acc_size, mem_wren, mem_d_in,
    output mem_d_out, mem_busy
  );
endinterface

// File: rtl/mem_arb_sel.sv
// Combinational winner select between IF and DM. MEM_ARB_RR_EN: the requester not
// recorded in ptr wins a tie; otherwise DM always beats IF and ptr is ignored.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic ptr,
  output logic any,
  output logic win
);
  assign any = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
  assign win = (if_req && dm_req) ? ((ptr == REQ_IF) ? REQ_DM : REQ_IF)
                                  : (dm_req ? REQ_DM : REQ_IF);
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign win = dm_req ? REQ_DM : REQ_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// IF/DM arbiter and burst sequencer for single-ported main memory (MEM_ARB_RR_EN selects round-robin).
// One command per transaction; holds in CMD while mem_busy, then streams N beats with no further stalls.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int ACCESS_SIZE  = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [ADDRESS_SIZE-1:0] ADDR_MASK = ~(ADDRESS_SIZE'(3));

  state_t                  state_q, state_d;
  logic                    owner_q, wren_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [ACCESS_SIZE-1:0]  acc_q;
  logic [4:0]              cnt_q, len;
  logic                    any, win, ptr, own_dm;
  logic                    gnt, done, rvalid, wack;

`ifdef MEM_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ptr_q <= REQ_IF;
    else if (state_q == ST_DONE) ptr_q <= owner_q;
  end
  assign ptr = ptr_q;
`else
  assign ptr = REQ_IF;
`endif

  mem_arb_sel u_sel (
    .if_req (bus.if_req),
    .dm_req (bus.dm_req),
    .ptr    (ptr),
    .any    (any),
    .win    (win)
  );

  assign len    = burst_len(acc_q);
  assign own_dm = (owner_q == REQ_DM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Winner fields are captured once; later req/addr changes do not affect the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= REQ_IF;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (any) begin
          owner_q <= win;
          addr_q  <= ((win == REQ_DM) ? bus.dm_addr : bus.if_addr) & ADDR_MASK;
          acc_q   <= (win == REQ_DM) ? bus.dm_acc_size : bus.if_acc_size;
          wren_q  <= (win == REQ_DM) && bus.dm_wren;
        end
        ST_CMD:   if (!bus.mem_busy) cnt_q <= '0;
        ST_BURST: cnt_q <= cnt_q + 5'd1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    bus.mem_en       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_acc_size = '0;
    bus.mem_wren     = 1'b0;
    bus.mem_d_in     = '0;
    gnt              = 1'b0;
    done             = 1'b0;
    rvalid           = 1'b0;
    wack             = 1'b0;
    case (state_q)
      ST_IDLE: if (any) state_d = ST_CMD;
      ST_CMD: begin
        bus.mem_en       = 1'b1;
        bus.mem_addr     = addr_q;
        bus.mem_acc_size = acc_q;
        bus.mem_wren     = wren_q;
        gnt              = 1'b1;
        if (!bus.mem_busy) begin
          // Write word 0 travels with the accepted command.
          if (wren_q) begin
            wack         = 1'b1;
            bus.mem_d_in = bus.dm_wdata;
            state_d      = (len == 5'd1) ? ST_DONE : ST_BURST;
          end else begin
            state_d      = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        gnt = 1'b1;
        if (wren_q) begin
          bus.mem_wren = 1'b1;
          bus.mem_d_in = bus.dm_wdata;
          wack         = 1'b1;
          if (cnt_q == len - 5'd2) state_d = ST_DONE;
        end else begin
          rvalid = 1'b1;
          if (cnt_q == len - 5'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.if_gnt    = gnt & ~own_dm;
  assign bus.dm_gnt    = gnt & own_dm;
  assign bus.if_done   = done & ~own_dm;
  assign bus.dm_done   = done & own_dm;
  assign bus.if_rvalid = rvalid & ~own_dm;
  assign bus.dm_rvalid = rvalid & own_dm;
  assign bus.if_rdata  = (rvalid && !own_dm) ? bus.mem_d_out : '0;
  assign bus.dm_rdata  = (rvalid && own_dm) ? bus.mem_d_out : '0;
  assign bus.dm_wack   = wack;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and burst sequencer in front of the single-ported main memory of the MIPS core. It shares the memory between the instruction-fetch (IF) and data-memory (DM) stages, issues one command per transaction, counts burst beats according to access size, and steers read data, write data and completion back to the owner.

## Interface
- ADDRESS_SIZE, 32, address width
- DATA_SIZE, 32, data word width
- ACCESS_SIZE, 2, access-size field width
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF request, level
- if_addr  in  ADDRESS_SIZE  IF base address
- if_acc_size  in  ACCESS_SIZE  IF burst size code
- if_gnt  out  1  IF owns memory
- if_rdata  out  DATA_SIZE  IF read word
- if_rvalid  out  1  if_rdata valid this cycle
- if_done  out  1  IF transaction complete, 1-cycle pulse
- dm_req  in  1  DM request, level
- dm_addr  in  ADDRESS_SIZE  DM base address
- dm_acc_size  in  ACCESS_SIZE  DM burst size code
- dm_wren  in  1  DM write (1) / read (0)
- dm_wdata  in  DATA_SIZE  DM current write word
- dm_wack  out  1  dm_wdata consumed this cycle; present next word next cycle
- dm_gnt, dm_rdata, dm_rvalid, dm_done  out  1/DATA_SIZE/1/1  as IF counterparts
- mem_en  out  1  command valid
- mem_addr  out  ADDRESS_SIZE  base address, bits [1:0] forced 0
- mem_acc_size  out  ACCESS_SIZE  burst size code
- mem_wren  out  1  write command
- mem_d_in  out  DATA_SIZE  write data to memory
- mem_d_out  in  DATA_SIZE  read data from memory
- mem_busy  in  1  memory cannot accept a command

## Operation
- Burst length N from acc_size: 00→1, 01→4, 10→8, 11→16 words; memory increments address internally.
- FSM states: IDLE, CMD, BURST, DONE.
- IDLE: if any req, pick winner, latch its addr/acc_size/wren, go CMD. No req: stay.
- Default arbitration fixed priority: DM beats IF.
- CMD: mem_en=1 with latched fields; owner gnt=1. Stay while mem_busy=1. On accept (mem_busy=0): read → BURST; write with N=1 → DONE; write N>1 → BURST.
- Write word k (k=0..N-1) driven on mem_d_in = dm_wdata in cycle accept+k; dm_wack=1 in each such cycle. mem_wren held through all write beats.
- Read word k valid on mem_d_out in cycle accept+1+k; routed to owner rdata with rvalid=1 (combinational pass-through).
- Beat counter 5 bits, cleared on accept; BURST exits to DONE after final beat. mem_busy ignored outside CMD.
- DONE: owner done=1, gnt=0, then IDLE.
- IF is read-only; mem_wren=0 for IF transactions.
- req deasserted mid-transaction is ignored; transaction completes.
- req still high in the IDLE cycle after DONE is a new request.
- Non-owner rdata/rvalid/wack/done stay 0; rdata of non-owner is 0.

## Timing
- Reset (async, any state): state IDLE, all outputs 0, counter 0, RR pointer = IF.
- Reset mid-burst: transaction abandoned, mem_en drops immediately, no done pulse.
- Read, req at cycle 0, mem_busy=0: CMD cycle 1, data cycles 2..N+1, DONE N+2, IDLE N+3.
- Write: CMD cycle 1 (word 0), word k in cycle 1+k, DONE cycle N+1.
- Each mem_busy cycle in CMD adds one cycle to all later events.
- Minimum gap between transactions: one IDLE cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; pointer records last-served requester, updated in DONE; on simultaneous requests the other requester wins; single requester always wins.
- Undefined: fixed priority DM > IF, no pointer register.

## Structure
- Package mem_arb_pkg: FSM state enum, ACC_* size codes, burst-length function, requester-id constants (REQ_IF, REQ_DM).
- Sub-module mem_arb_sel: combinational winner select from if_req, dm_req and RR pointer (pointer input unused without MEM_ARB_RR_EN).

## Test plan
- IF read acc_size 01 at 0x100, mem_busy=0 → mem_en cycle 1 addr 0x100, if_rvalid cycles 2-5, if_done cycle 6.
- DM write acc_size 00 data 0xDEADBEEF → mem_wren=1, mem_d_in=0xDEADBEEF cycle 1, dm_wack cycle 1, dm_done cycle 2.
- IF and DM request same cycle, held through two transactions → DM first; without MEM_ARB_RR_EN DM again; with it IF second.
- mem_busy high 3 cycles during CMD → mem_en held 4 cycles, fields stable, read beats shift by 3.
- DM write acc_size 11 at 0x203 → mem_addr 0x200, 16 dm_wack pulses, dm_done after last.
- rst asserted mid 8-word read → outputs 0 asynchronously, IDLE; new if_req after release served normally.
